bpu_btb: RTL

//  Branch target buffer and direction predictor: the consumer end of the bru_info resolution stream.
//  - Fetch side: looked up with the fetch PC; answers one cycle later.
//  - Resolve side: trained by the branch resolution unit's bru_info output (one record per cycle max).

---
 rtl/bpu_btb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters, looked up by fetch and
// trained by resolved branches. Optional committed return stack: define BPU_RAS_EN.
module bpu_btb #(
  parameter int BTB_ENTRIES = 64,
  parameter int RAS_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [2:0]  pred_type,
  input  logic        bru_valid,
  input  logic [31:0] bru_pc,
  input  logic [31:0] bru_true_pc,
  input  logic        bru_taken,
  input  logic [2:0]  bru_type
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // BranchType_E encoding
  localparam logic [2:0] BT_NONE   = 3'd0;
  localparam logic [2:0] BT_BRANCH = 3'd1;
  localparam logic [2:0] BT_CALL   = 3'd3;
  localparam logic [2:0] BT_RETURN = 3'd4;

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [31:0]            target_q [BTB_ENTRIES];
  logic [2:0]             type_q   [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic        upd_valid_q, upd_valid_d;
  logic [31:0] upd_pc_q, upd_pc_d;
  logic [31:0] upd_true_pc_q, upd_true_pc_d;
  logic        upd_taken_q, upd_taken_d;
  logic [2:0]  upd_type_q, upd_type_d;

  logic        pred_hit_q, pred_hit_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic [2:0]  pred_type_q, pred_type_d;

  logic [IDX_W-1:0] u_idx, lk_idx;
  logic [TAG_W-1:0] u_tag, lk_tag;
  logic             u_hit, lk_hit;
  logic             wr_en;
  logic [31:0]      wr_target;
  logic [1:0]       wr_ctr;

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc_q[1:0]};

`ifdef BPU_RAS_EN
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam logic [RAS_W:0] RAS_FULL = (RAS_W+1)'(RAS_DEPTH);

  logic [31:0]      ras_q [RAS_DEPTH];
  logic [RAS_W-1:0] sp_q, sp_d, top_idx;
  logic [RAS_W:0]   count_q, count_d;
  logic             ras_push;

  assign top_idx = sp_q - 1'b1;

  // Push at sp overwrites the oldest slot once the stack has wrapped
  always_comb begin
    sp_d     = sp_q;
    count_d  = count_q;
    ras_push = 1'b0;
    if (upd_valid_q && upd_type_q == BT_CALL) begin
      ras_push = 1'b1;
      sp_d     = sp_q + 1'b1;
      if (count_q != RAS_FULL) count_d = count_q + 1'b1;
    end else if (upd_valid_q && upd_type_q == BT_RETURN && count_q != '0) begin
      sp_d    = sp_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ras_push) ras_q[sp_q] <= upd_pc_q + 32'd8;
  end
`else
  localparam int RAS_UNUSED = RAS_DEPTH;
`endif

  always_comb begin
    upd_valid_d   = bru_valid && (bru_type != BT_NONE);
    upd_pc_d      = bru_pc;
    upd_true_pc_d = bru_true_pc;
    upd_taken_d   = bru_taken;
    upd_type_d    = bru_type;
  end

  assign u_idx = upd_pc_q[IDX_W+1:2];
  assign u_tag = upd_pc_q[31:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[u_idx];
    wr_ctr    = ctr_q[u_idx];
    if (upd_valid_q) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_type_q == BT_BRANCH) begin
          if (upd_taken_q) begin
            wr_target = upd_true_pc_q;
            if (ctr_q[u_idx] != 2'b11) wr_ctr = ctr_q[u_idx] + 2'd1;
          end else if (ctr_q[u_idx] != 2'b00) begin
            wr_ctr = ctr_q[u_idx] - 2'd1;
          end
        end else begin
          wr_target = upd_true_pc_q;
          wr_ctr    = 2'b11;
        end
      end else if (upd_taken_q) begin
        // Miss (empty or aliased): allocate over whatever sits at this index
        wr_en     = 1'b1;
        wr_target = upd_true_pc_q;
        wr_ctr    = (upd_type_q == BT_BRANCH) ? 2'b10 : 2'b11;
      end
    end
    valid_d = valid_q;
    if (wr_en) valid_d[u_idx] = 1'b1;
  end

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[31:IDX_W+2];
  assign lk_hit = if_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  always_comb begin
    pred_hit_d    = lk_hit;
    pred_taken_d  = lk_hit && ((type_q[lk_idx] != BT_BRANCH) || ctr_q[lk_idx][1]);
    pred_target_d = lk_hit ? target_q[lk_idx] : 32'd0;
    pred_type_d   = lk_hit ? type_q[lk_idx] : BT_NONE;
`ifdef BPU_RAS_EN
    if (lk_hit && type_q[lk_idx] == BT_RETURN && count_q != '0) pred_target_d = ras_q[top_idx];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      upd_valid_q   <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_type_q   <= BT_NONE;
    end else begin
      valid_q       <= valid_d;
      upd_valid_q   <= upd_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_type_q   <= pred_type_d;
    end
  end

  always_ff @(posedge clk) begin
    upd_pc_q      <= upd_pc_d;
    upd_true_pc_q <= upd_true_pc_d;
    upd_taken_q   <= upd_taken_d;
    upd_type_q    <= upd_type_d;
  end

  // Entry payload carries no reset; the valid vector alone marks live entries
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= wr_target;
      type_q[u_idx]   <= upd_type_q;
      ctr_q[u_idx]    <= wr_ctr;
    end
  end

  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_type   = pred_type_q;

endmodule
